// File: rtl/ecg_hybrid_encoder_seq_if.sv
// ecg_hybrid_encoder_seq_if
//   Stream bundle between the ECG sample front-end, the hybrid encoder and
//   the bit packer.
//   Sample side : s_valid, s_ready, s_data (signed), flush
//   Token side  : m_valid, m_ready, m_type, m_data
//   Status      : k_out (GR parameter of current block), busy
//   master = sample source / token sink, slave = encoder.
interface ecg_hybrid_encoder_seq_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              flush;
    logic              m_valid;
    logic              m_ready;
    logic [1:0]        m_type;
    logic [DATA_W-1:0] m_data;
    logic [2:0]        k_out;
    logic              busy;

    modport master (
        output s_valid, s_data, flush, m_ready,
        input  s_ready, m_valid, m_type, m_data, k_out, busy
    );

    modport slave (
        input  s_valid, s_data, flush, m_ready,
        output s_ready, m_valid, m_type, m_data, k_out, busy
    );
endinterface

// File: rtl/ecg_hybrid_encoder_seq.sv
// ecg_hybrid_encoder_seq
//   Block-based ECG compressor: buffers BLOCK_N first differences, chooses a
//   Golomb-Rice parameter k from the mean absolute delta, then emits a token
//   stream of HDR(k), RUN(zero count), GR(codeword) and ESC(raw delta).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    ecg_hybrid_encoder_seq_if.slave (sample stream in, token stream
//            out, flush, k_out, busy)
//   GR codeword layout: [K_MAX-1:0]=r, [K_MAX+Q_W-1:K_MAX]=q, [K_MAX+Q_W]=sign.
//
//   state  | meaning
//   FILL   | accept samples, store deltas; flush check when buffer empty
//   CALC   | mean |delta| -> k, load header token
//   HDR    | header token presented
//   ENC    | examine buf[idx]: extend zero run or load RUN/GR/ESC token
//   EMIT   | token presented; pend means a GR/ESC follows for same idx
//   FLUSH  | flushed RUN token presented
module ecg_hybrid_encoder_seq #(
    parameter int DATA_W  = 16,
    parameter int BLOCK_N = 8,
    parameter int RUN_W   = 6,
    parameter int Q_W     = 4,
    parameter int TH1     = 100,
    parameter int TH2     = 500,
    parameter int K_LO    = 3,
    parameter int K_MID   = 4,
    parameter int K_HI    = 5
) (
    input logic                      clk,
    input logic                      rst_n,
    ecg_hybrid_encoder_seq_if.slave  bus
);
    localparam int LOG2N = $clog2(BLOCK_N);
    localparam int SUM_W = DATA_W + LOG2N;
    localparam int K_MAX = K_HI;
    localparam logic [1:0] T_HDR = 2'd0;
    localparam logic [1:0] T_RUN = 2'd1;
    localparam logic [1:0] T_GR  = 2'd2;
    localparam logic [1:0] T_ESC = 2'd3;
    localparam logic [DATA_W-1:0] Q_MAX = DATA_W'(2**Q_W - 1);
    localparam logic [LOG2N-1:0]  LAST  = LOG2N'(BLOCK_N - 1);

    typedef enum logic [2:0] {
        S_FILL, S_CALC, S_HDR, S_ENC, S_EMIT, S_FLUSH
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] dbuf [BLOCK_N];
    logic [DATA_W-1:0] prev;
    logic [RUN_W-1:0]  run;
    logic [LOG2N-1:0]  cnt;
    logic [LOG2N-1:0]  idx;
    logic              pend;
    logic              s_ready_q;
    logic              m_valid_q;
    logic [1:0]        m_type_q;
    logic [DATA_W-1:0] m_data_q;
    logic [2:0]        k_q;

    // Most negative value has no positive twin; clamp it.
    function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] d);
        if (d == {1'b1, {(DATA_W-1){1'b0}}})
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (d[DATA_W-1])
            return -d;
        else
            return d;
    endfunction

    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] mean;
    logic [2:0]        k_calc;

    always_comb begin
        sum = '0;
        for (int j = 0; j < BLOCK_N; j++)
            sum = sum + SUM_W'(abs_sat(dbuf[j]));
        mean = DATA_W'(sum >> LOG2N);
        if (32'(mean) < TH1)
            k_calc = 3'(K_LO);
        else if (32'(mean) < TH2)
            k_calc = 3'(K_MID);
        else
            k_calc = 3'(K_HI);
    end

    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] cur_abs;
    logic [DATA_W-1:0] q_full;
    logic [DATA_W-1:0] r_val;
    logic              esc;
    logic [1:0]        cw_type;
    logic [DATA_W-1:0] cw_data;
    logic [RUN_W-1:0]  run_inc;
    logic              run_full;

    always_comb begin
        cur     = dbuf[idx];
        cur_abs = abs_sat(cur);
        q_full  = cur_abs >> k_q;
        r_val   = cur_abs & ((DATA_W'(1) << k_q) - DATA_W'(1));
        esc     = q_full > Q_MAX;
        cw_type = esc ? T_ESC : T_GR;
        cw_data = esc ? cur
                      : ((DATA_W'(cur[DATA_W-1]) << (K_MAX + Q_W))
                         | ((q_full & Q_MAX) << K_MAX)
                         | r_val);
        run_inc  = run + RUN_W'(1);
        run_full = (run_inc == {RUN_W{1'b1}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FILL;
            for (int j = 0; j < BLOCK_N; j++)
                dbuf[j] <= '0;
            prev      <= '0;
            run       <= '0;
            cnt       <= '0;
            idx       <= '0;
            pend      <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_type_q  <= T_HDR;
            m_data_q  <= '0;
            k_q       <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    s_ready_q <= 1'b1;
                    if (bus.s_valid && s_ready_q) begin
                        dbuf[cnt] <= bus.s_data - prev;
                        prev      <= bus.s_data;
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            state     <= S_CALC;
                            s_ready_q <= 1'b0;
                        end else begin
                            cnt <= cnt + LOG2N'(1);
                        end
                    end
                    // A sample accepted in the same cycle still counts; the
                    // block simply resumes filling after the RUN token.
                    if (bus.flush && cnt == '0 && run != '0) begin
                        m_valid_q <= 1'b1;
                        m_type_q  <= T_RUN;
                        m_data_q  <= DATA_W'(run);
                        run       <= '0;
                        state     <= S_FLUSH;
                        s_ready_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    k_q       <= k_calc;
                    m_valid_q <= 1'b1;
                    m_type_q  <= T_HDR;
                    m_data_q  <= DATA_W'(k_calc);
                    state     <= S_HDR;
                end
                S_HDR: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        idx       <= '0;
                        state     <= S_ENC;
                    end
                end
                S_ENC: begin
                    if (cur == '0) begin
                        if (run_full) begin
                            run       <= '0;
                            m_valid_q <= 1'b1;
                            m_type_q  <= T_RUN;
                            m_data_q  <= DATA_W'(run_inc);
                            pend      <= 1'b0;
                            state     <= S_EMIT;
                        end else begin
                            run <= run_inc;
                            if (idx == LAST) begin
                                state     <= S_FILL;
                                s_ready_q <= 1'b1;
                            end else begin
                                idx <= idx + LOG2N'(1);
                            end
                        end
                    end else if (run != '0) begin
                        run       <= '0;
                        m_valid_q <= 1'b1;
                        m_type_q  <= T_RUN;
                        m_data_q  <= DATA_W'(run);
                        pend      <= 1'b1;
                        state     <= S_EMIT;
                    end else begin
                        m_valid_q <= 1'b1;
                        m_type_q  <= cw_type;
                        m_data_q  <= cw_data;
                        pend      <= 1'b0;
                        state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (bus.m_ready) begin
                        if (pend) begin
                            m_type_q <= cw_type;
                            m_data_q <= cw_data;
                            pend     <= 1'b0;
                        end else begin
                            m_valid_q <= 1'b0;
                            if (idx == LAST) begin
                                state     <= S_FILL;
                                s_ready_q <= 1'b1;
                            end else begin
                                idx   <= idx + LOG2N'(1);
                                state <= S_ENC;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state     <= S_FILL;
                        s_ready_q <= 1'b1;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_type  = m_type_q;
    assign bus.m_data  = m_data_q;
    assign bus.k_out   = k_q;
    assign bus.busy    = (state != S_FILL);
endmodule

// File: tb/tb_ecg_hybrid_encoder_seq.sv
// tb_ecg_hybrid_encoder_seq
//   Directed bench for ecg_hybrid_encoder_seq with a token scoreboard fed by
//   a behavioural model of the block encoder.
module tb_ecg_hybrid_encoder_seq;
    typedef struct packed {
        logic [1:0]  t;
        logic [15:0] d;
    } tok_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ecg_hybrid_encoder_seq_if #(.DATA_W(16)) bus ();

    ecg_hybrid_encoder_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   tests = 0;
    int   fails = 0;
    tok_t exp_q[$];
    int   blk[8];
    int   m_prev = 0;
    int   m_run  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int t, input int d);
        tok_t x;
        x.t = 2'(t);
        x.d = 16'(d);
        exp_q.push_back(x);
    endtask

    // Reference encoder for one block held in blk[].
    task automatic model_block();
        int ds[8];
        int a[8];
        int sum;
        int k;
        int q;
        int r;
        int raw;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            raw = (blk[i] - m_prev) & 32'hFFFF;
            m_prev = blk[i] & 32'hFFFF;
            ds[i] = (raw >= 32768) ? raw - 65536 : raw;
            a[i]  = (ds[i] < 0) ? -ds[i] : ds[i];
            if (a[i] > 32767) a[i] = 32767;
            sum += a[i];
        end
        sum = sum / 8;
        k = (sum < 100) ? 3 : (sum < 500) ? 4 : 5;
        push(0, k);
        for (int i = 0; i < 8; i++) begin
            if (ds[i] == 0) begin
                m_run++;
                if (m_run == 63) begin
                    push(1, 63);
                    m_run = 0;
                end
            end else begin
                if (m_run > 0) push(1, m_run);
                m_run = 0;
                q = a[i] / (1 << k);
                r = a[i] % (1 << k);
                if (q > 15) push(3, ds[i] & 32'hFFFF);
                else        push(2, ((ds[i] < 0) ? 512 : 0) + q * 32 + r);
            end
        end
    endtask

    // Scoreboard: compare every accepted token against the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("tok_type", 32'(bus.m_type), 32'(exp_q[0].t));
                chk("tok_data", 32'(bus.m_data), 32'(exp_q[0].d));
                if (exp_q[0].t == 2'd0)
                    chk("hdr_k_out", 32'(bus.k_out), 32'(exp_q[0].d));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_prev = 0;
        m_run  = 0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input int v);
        bit ok;
        ok = 1'b0;
        bus.s_data  = 16'(v);
        bus.s_valid = 1'b1;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        bus.s_valid = 1'b0;
        chk("s_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_block();
        model_block();
        for (int i = 0; i < 8; i++) send_sample(blk[i]);
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy && !bus.m_valid) done = 1'b1;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_gr(output bit found);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk);
            #1;
            if (bus.m_valid && bus.m_type == 2'd2) found = 1'b1;
        end
        chk("gr_seen", 32'(found), 32'd1);
    endtask

    initial begin
        bit found;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;

        // Reset state, sampled while rst_n is low
        #3;
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_k_out",   32'(bus.k_out),   32'd0);
        chk("rst_m_type",  32'(bus.m_type),  32'd0);
        chk("rst_m_data",  32'(bus.m_data),  32'd0);

        // Ramp by 10: k=3, RUN(1) then GR q=1 r=2
        do_reset();
        for (int i = 0; i < 8; i++) blk[i] = 10 * i;
        send_block();
        drain("drain_ramp10");
        chk("k_ramp10", 32'(bus.k_out), 32'd3);

        // Ramp by 200: k=4, no RUN; stall the GR stream for 5 cycles
        do_reset();
        for (int i = 0; i < 8; i++) blk[i] = 200 * (i + 1);
        send_block();
        wait_gr(found);
        bus.m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid",   32'(bus.m_valid), 32'd1);
            chk("stall_type",    32'(bus.m_type),  32'(exp_q[0].t));
            chk("stall_data",    32'(bus.m_data),  32'(exp_q[0].d));
            chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
        end
        bus.m_ready = 1'b1;
        drain("drain_ramp200");
        chk("k_ramp200", 32'(bus.k_out), 32'd4);

        // Ramp by 1000: k=5, quotient overflow -> ESC
        do_reset();
        for (int i = 0; i < 8; i++) blk[i] = 1000 * (i + 1);
        send_block();
        drain("drain_ramp1000");
        chk("k_ramp1000", 32'(bus.k_out), 32'd5);

        // Alternating 0/-16: signed codewords
        do_reset();
        for (int i = 0; i < 8; i++) blk[i] = (i % 2 == 1) ? -16 : 0;
        send_block();
        drain("drain_alt");

        // Saturating abs: delta of -32768
        do_reset();
        for (int i = 0; i < 8; i++) blk[i] = (i % 2 == 1) ? -32768 : 0;
        send_block();
        drain("drain_sat");

        // 72 zeros: RUN(63) when the counter fills, RUN(9) on flush
        do_reset();
        for (int i = 0; i < 8; i++) blk[i] = 0;
        for (int b = 0; b < 9; b++) send_block();
        drain("drain_zeros");
        chk("run_pending", 32'(m_run), 32'd9);
        push(1, m_run);
        m_run = 0;
        @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        drain("drain_flush");

        // Reset mid-ENC, then a fresh block must match a clean start
        do_reset();
        for (int i = 0; i < 8; i++) blk[i] = 10 * i;
        send_block();
        wait_gr(found);
        rst_n = 1'b0;
        exp_q.delete();
        m_prev = 0;
        m_run  = 0;
        @(negedge clk);
        chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_busy",    32'(bus.busy),    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) blk[i] = 200 * (i + 1);
        send_block();
        drain("drain_after_rst");
        chk("k_after_rst", 32'(bus.k_out), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
